gobang_scan_ctrl: RTL

//  Sequencer for the board datapath's strategy/checker lookup port.
//  On start, sweeps consider_i/consider_j over all 15x15 cells in raster order.
//  For each cell it waits for the external evaluator and samples its score; occupied cells are skipped.

---
 rtl/gobang_scan_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/gobang_scan_ctrl.sv
// Raster sweep over the 15x15 board driving the evaluator lookup port; tracks the
// highest-scoring empty cell and reports it with a one-cycle done pulse.
module gobang_scan_ctrl #(
    parameter int unsigned SCORE_W  = 16,
    parameter int unsigned EVAL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               occupied,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         consider_i,
    output logic [3:0]         consider_j,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [3:0]         best_i,
    output logic [3:0]         best_j,
    output logic [SCORE_W-1:0] best_score
);

    localparam logic [3:0] LatInit = 4'(EVAL_LAT);
    localparam logic [3:0] LastIdx = 4'd14;

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e     state_q;
    logic [3:0] wait_cnt_q;

    logic take;
    assign take = !occupied && (!found || (score > best_score));

    // consider_i/j are the cell counters themselves, so they are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            consider_i <= '0;
            consider_j <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            best_i     <= '0;
            best_j     <= '0;
            best_score <= '0;
        end else if (abort) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            consider_i <= '0;
            consider_j <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            best_i     <= '0;
            best_j     <= '0;
            best_score <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q    <= StEval;
                        wait_cnt_q <= LatInit;
                        consider_i <= '0;
                        consider_j <= '0;
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        best_i     <= '0;
                        best_j     <= '0;
                        best_score <= '0;
                    end
                end
                StEval: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end else begin
                        if (take) begin
                            found      <= 1'b1;
                            best_i     <= consider_i;
                            best_j     <= consider_j;
                            best_score <= score;
                        end
                        if (consider_i == LastIdx && consider_j == LastIdx) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            wait_cnt_q <= LatInit;
                            if (consider_j == LastIdx) begin
                                consider_j <= '0;
                                consider_i <= consider_i + 4'd1;
                            end else begin
                                consider_j <= consider_j + 4'd1;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    consider_i <= '0;
                    consider_j <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
